// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Burst counter must be able to hold the value MAX_BURST itself.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return safe_clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = safe_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the pointer itself is checked last.
    always_comb begin
        int unsigned cand;
        logic [PTR_W-1:0] cand_idx;
        pick_o   = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr_i) + i) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o            = 1'b1;
                idx_o            = cand_idx;
                pick_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts until Last, MAX_BURST accepted words, or the owner drops valid.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_Req_Valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_Req_Data,
    input  logic [NUM_REQ-1:0]       i_Req_Last,
    output logic [NUM_REQ-1:0]       o_Req_Ready,
    input  logic                     i_Full,
    output logic                     o_WR_En,
    output logic [WIDTH-1:0]         o_WR_Data,
    output logic [NUM_REQ-1:0]       o_Grant,
    output logic                     o_Busy
);

    localparam int unsigned PtrW = safe_clog2(NUM_REQ);
    localparam int unsigned CntW = cnt_width(MAX_BURST);

    arb_state_t      state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick;
    logic [PtrW-1:0]    pick_idx;
    logic               pick_any;

    logic g_valid;
    logic g_last;
    logic accept;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PtrW)
    ) u_picker (
        .req_i  (i_Req_Valid),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Output muxes: the pointer doubles as the granted index while in ARB_GRANT.
    always_comb begin
        o_Req_Ready = '0;
        o_WR_En     = 1'b0;
        o_WR_Data   = '0;
        o_Grant     = '0;
        o_Busy      = 1'b0;
        g_valid     = i_Req_Valid[ptr_q];
        g_last      = i_Req_Last[ptr_q];
        accept      = 1'b0;
        if (state_q == ARB_GRANT) begin
            o_Busy             = 1'b1;
            o_Grant            = NUM_REQ'(1) << ptr_q;
            o_Req_Ready[ptr_q] = ~i_Full;
            accept             = g_valid & ~i_Full;
            o_WR_En            = accept;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (ptr_q == PtrW'(k)) begin
                    o_WR_Data = i_Req_Data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next state: pick in IDLE, count accepted words and decide release in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                if (accept) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // Owner going idle releases even under Full; Last only counts when accepted.
                if (!g_valid || (accept && g_last) ||
                    (accept && (cnt_q + CntW'(1) == CntW'(MAX_BURST)))) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; reset leaves req0 as highest priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= PtrW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
